// File: rtl/csi2_pkt_scheduler.sv
// Round-robin scheduler: grants one of four RX channel FIFOs and streams its packet to the TX link.
// Latency: grant one cycle after req_i; backpressure: waits on hs_ready_i before XFER, never stalls inside XFER.
module csi2_pkt_scheduler #(
    parameter int RX_GEAR    = 8,
    parameter int PKT_GAP    = 4,
    parameter int HS_TIMEOUT = 1023
) (
    input  logic        clk_byte_i,
    input  logic        reset_byte_i,
    input  logic [3:0]  req_i,
    input  logic [3:0]  sp_i,
    input  logic [63:0] wc_i,
    input  logic        hs_ready_i,
    output logic [3:0]  grant_o,
    output logic [1:0]  ch_o,
    output logic        rd_en_o,
    output logic        eop_o,
    output logic        hs_req_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int          BPB      = RX_GEAR / 8;
    localparam logic [15:0] HS_LAST  = 16'(HS_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST = 8'(PKT_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        HS_REQ,
        XFER,
        TRAIL,
        GAP
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic        sp_q;
    logic [15:0] wc_q;
    logic [15:0] hs_timer;
    logic [7:0]  gap_cnt;
    logic [16:0] beat_cnt;

    logic [16:0] pkt_bytes;
    logic [16:0] pkt_beats;
    logic [1:0]  sel;
    logic        sel_vld;

    // 17-bit arithmetic so wc=0xFFFF (65541 bytes) cannot wrap.
    always_comb begin
        pkt_bytes = sp_q ? 17'd4 : ({1'b0, wc_q} + 17'd6);
        pkt_beats = (BPB == 2) ? ((pkt_bytes + 17'd1) >> 1) : pkt_bytes;
    end

    // Scan downward so the requester closest to ptr is the one that sticks.
    always_comb begin
        sel     = ptr;
        sel_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[ptr + 2'(i)]) begin
                sel     = ptr + 2'(i);
                sel_vld = 1'b1;
            end
        end
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_byte_i) begin
        if (reset_byte_i) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sp_q     <= 1'b0;
            wc_q     <= 16'd0;
            hs_timer <= 16'd0;
            gap_cnt  <= 8'd0;
            beat_cnt <= 17'd0;
            grant_o  <= 4'd0;
            ch_o     <= 2'd0;
            rd_en_o  <= 1'b0;
            eop_o    <= 1'b0;
            hs_req_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant_o  <= 4'b0001 << sel;
                        ch_o     <= sel;
                        sp_q     <= sp_i[sel];
                        wc_q     <= wc_i[{sel, 4'b0000} +: 16];
                        hs_req_o <= 1'b1;
                        hs_timer <= 16'd0;
                        state    <= HS_REQ;
                    end
                end
                HS_REQ: begin
                    if (hs_ready_i) begin
                        rd_en_o  <= 1'b1;
                        beat_cnt <= 17'd1;
                        eop_o    <= (pkt_beats == 17'd1);
                        state    <= XFER;
                    end else if (hs_timer == HS_LAST) begin
                        err_o    <= 1'b1;
                        grant_o  <= 4'd0;
                        hs_req_o <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        hs_timer <= hs_timer + 16'd1;
                    end
                end
                XFER: begin
                    if (beat_cnt == pkt_beats) begin
                        rd_en_o  <= 1'b0;
                        eop_o    <= 1'b0;
                        grant_o  <= 4'd0;
                        hs_req_o <= 1'b0;
                        ptr      <= ch_o + 2'd1;
                        state    <= TRAIL;
                    end else begin
                        beat_cnt <= beat_cnt + 17'd1;
                        eop_o    <= ((beat_cnt + 17'd1) == pkt_beats);
                    end
                end
                TRAIL: begin
                    if (!hs_ready_i) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csi2_pkt_scheduler.sv
module tb_csi2_pkt_scheduler;
    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  req      = 4'd0;
    logic [3:0]  sp       = 4'd0;
    logic [63:0] wc       = 64'd0;
    logic        hs_ready = 1'b0;

    logic [3:0] grant_a, grant_b;
    logic [1:0] ch_a, ch_b;
    logic       rd_a, rd_b, eop_a, eop_b, hsr_a, hsr_b, busy_a, busy_b, err_a, err_b;

    bit         use_b = 1'b0;
    logic [3:0] m_grant;
    logic       m_rd, m_eop, m_hsr, m_busy;
    assign m_grant = use_b ? grant_b : grant_a;
    assign m_rd    = use_b ? rd_b    : rd_a;
    assign m_eop   = use_b ? eop_b   : eop_a;
    assign m_hsr   = use_b ? hsr_b   : hsr_a;
    assign m_busy  = use_b ? busy_b  : busy_a;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ch;
        int beats;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    csi2_pkt_scheduler #(.RX_GEAR(8), .PKT_GAP(4), .HS_TIMEOUT(8)) dut_a (
        .clk_byte_i(clk), .reset_byte_i(reset), .req_i(req), .sp_i(sp), .wc_i(wc),
        .hs_ready_i(hs_ready), .grant_o(grant_a), .ch_o(ch_a), .rd_en_o(rd_a),
        .eop_o(eop_a), .hs_req_o(hsr_a), .busy_o(busy_a), .err_o(err_a)
    );

    csi2_pkt_scheduler #(.RX_GEAR(16), .PKT_GAP(4), .HS_TIMEOUT(8)) dut_b (
        .clk_byte_i(clk), .reset_byte_i(reset), .req_i(req), .sp_i(sp), .wc_i(wc),
        .hs_ready_i(hs_ready), .grant_o(grant_b), .ch_o(ch_b), .rd_en_o(rd_b),
        .eop_o(eop_b), .hs_req_o(hsr_b), .busy_o(busy_b), .err_o(err_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset    = 1'b1;
        req      = 4'd0;
        hs_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({grant_a, ch_a, rd_a, eop_a, hsr_a, busy_a, err_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs %b, want all zero", {grant_a, ch_a, rd_a, eop_a, hsr_a, busy_a, err_a});
        end
        n_checks++;
        if ({grant_b, ch_b, rd_b, eop_b, hsr_b, busy_b, err_b} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs %b, want all zero", {grant_b, ch_b, rd_b, eop_b, hsr_b, busy_b, err_b});
        end
        reset = 1'b0;
    endtask

    task automatic xfer_pkt(input int ch, input bit short_pkt, input logic [15:0] wcv, input int delay);
        exp_t e, got;
        int   bytes, cnt, eop_n, eop_at, guard;
        bytes   = short_pkt ? 4 : int'(wcv) + 6;
        e.ch    = ch;
        e.beats = use_b ? (bytes + 1) / 2 : bytes;
        exp_q.push_back(e);
        sp          = 4'd0;
        sp[ch]      = short_pkt;
        wc          = 64'd0;
        wc[16*ch +: 16] = wcv;
        req         = 4'b0001 << ch;
        hs_ready    = 1'b0;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (m_grant == 4'd0 && guard < 50);
        got = exp_q.pop_front();
        n_checks++;
        if (m_grant !== (4'b0001 << got.ch)) begin
            n_fail++;
            $display("FAIL pkt_grant: got %b want %b", m_grant, 4'b0001 << got.ch);
        end
        n_checks++;
        if (m_hsr !== 1'b1) begin
            n_fail++;
            $display("FAIL pkt_hs_req: got %b want 1", m_hsr);
        end
        req = 4'd0;
        repeat (delay) tick();
        hs_ready = 1'b1;
        cnt = 0; eop_n = 0; eop_at = 0; guard = 0;
        while (guard < got.beats + 50) begin
            tick();
            guard++;
            if (m_rd) cnt++;
            if (m_eop) begin
                eop_n++;
                eop_at = cnt;
            end
            if (cnt > 0 && !m_rd) break;
        end
        n_checks++;
        if (cnt != got.beats) begin
            n_fail++;
            $display("FAIL pkt_beats: got %0d rd_en cycles want %0d", cnt, got.beats);
        end
        n_checks++;
        if (eop_n != 1 || eop_at != got.beats) begin
            n_fail++;
            $display("FAIL pkt_eop: got %0d pulses at beat %0d want 1 at beat %0d", eop_n, eop_at, got.beats);
        end
        n_checks++;
        if (m_hsr !== 1'b0 || m_grant !== 4'd0) begin
            n_fail++;
            $display("FAIL pkt_trail: hs_req %b grant %b want 0 and 0000", m_hsr, m_grant);
        end
        hs_ready = 1'b0;
        guard = 0;
        while (m_busy && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_idle: busy %b want 0", m_busy);
        end
    endtask

    task automatic test_long_pkt();
        xfer_pkt(2, 1'b0, 16'd10, 3);
        xfer_pkt(3, 1'b1, 16'd0, 0);
    endtask

    task automatic test_gear16();
        use_b = 1'b1;
        do_reset();
        xfer_pkt(0, 1'b1, 16'd0, 2);
        xfer_pkt(0, 1'b0, 16'd1, 1);
        use_b = 1'b0;
    endtask

    task automatic test_round_robin();
        exp_t       e, got;
        logic [3:0] prev;
        int         seen, idle, guard;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e.ch    = i % 4;
            e.beats = 4;
            exp_q.push_back(e);
        end
        req = 4'hf; sp = 4'hf; wc = 64'd0;
        prev = 4'd0; seen = 0; idle = 0; guard = 0;
        while (seen < 5 && guard < 400) begin
            tick();
            guard++;
            hs_ready = m_hsr;
            if (m_grant != 4'd0 && prev == 4'd0) begin
                got = exp_q.pop_front();
                n_checks++;
                if (m_grant !== (4'b0001 << got.ch)) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %b want %b", seen, m_grant, 4'b0001 << got.ch);
                end
                if (seen > 0) begin
                    n_checks++;
                    if (idle < 4) begin
                        n_fail++;
                        $display("FAIL rr_gap[%0d]: got %0d idle cycles want >= 4", seen, idle);
                    end
                end
                seen++;
                idle = 0;
            end else if (m_grant == 4'd0) begin
                idle++;
            end
            prev = m_grant;
        end
        n_checks++;
        if (seen != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants want 5", seen);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        exp_t e, got;
        int   guard, hs_cnt;
        do_reset();
        e.ch = 1; e.beats = 0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        req = 4'b0110; sp = 4'b0110; hs_ready = 1'b0;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (grant_a == 4'd0 && guard < 50);
        got = exp_q.pop_front();
        n_checks++;
        if (grant_a !== (4'b0001 << got.ch)) begin
            n_fail++;
            $display("FAIL to_grant: got %b want %b", grant_a, 4'b0001 << got.ch);
        end
        hs_cnt = 0; guard = 0;
        while (hsr_a && guard < 50) begin
            hs_cnt++;
            tick();
            guard++;
        end
        n_checks++;
        if (hs_cnt != 8) begin
            n_fail++;
            $display("FAIL to_cycles: got %0d hs_req cycles want 8", hs_cnt);
        end
        n_checks++;
        if (err_a !== 1'b1 || grant_a !== 4'd0) begin
            n_fail++;
            $display("FAIL to_err: err %b grant %b want 1 and 0000", err_a, grant_a);
        end
        tick();
        got = exp_q.pop_front();
        n_checks++;
        if (err_a !== 1'b0 || grant_a !== (4'b0001 << got.ch)) begin
            n_fail++;
            $display("FAIL to_regrant: err %b grant %b want 0 and %b", err_a, grant_a, 4'b0001 << got.ch);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_xfer();
        int guard;
        do_reset();
        xfer_pkt(2, 1'b0, 16'd10, 1);
        sp = 4'd0; wc = 64'd0; wc[31:16] = 16'd10; req = 4'b0010; hs_ready = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!rd_a && guard < 50);
        n_checks++;
        if (rd_a !== 1'b1 || grant_a !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_xfer_start: rd_en %b grant %b want 1 and 0010", rd_a, grant_a);
        end
        repeat (3) tick();
        reset = 1'b1;
        req   = 4'hf;
        tick();
        n_checks++;
        if ({grant_a, ch_a, rd_a, eop_a, hsr_a, busy_a, err_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_xfer_reset: outputs %b want all zero", {grant_a, ch_a, rd_a, eop_a, hsr_a, busy_a, err_a});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (grant_a !== 4'b0001 || rd_a !== 1'b0 || eop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_xfer_ptr: grant %b rd_en %b eop %b want 0001 0 0", grant_a, rd_a, eop_a);
        end
        do_reset();
    endtask

    task automatic test_max_wc();
        do_reset();
        xfer_pkt(3, 1'b0, 16'hFFFF, 1);
    endtask

    initial begin
        test_reset();
        test_long_pkt();
        test_gear16();
        test_round_robin();
        test_timeout();
        test_reset_mid_xfer();
        test_max_wc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csi2_pkt_scheduler.md
CSI2_PKT_SCHEDULER -- requirements
Module: csi2_pkt_scheduler

Interface
REQ-001 Parameter RX_GEAR, default 8, datapath width in bits (8 or 16); bytes per beat BPB = RX_GEAR/8.
REQ-002 Parameter PKT_GAP, default 4, idle cycles between packets (1..255).
REQ-003 Parameter HS_TIMEOUT, default 1023, maximum cycles spent waiting for hs_ready_i (1..65535).
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_byte_i  in  1  byte clock; the only clock.
REQ-006 reset_byte_i  in  1  synchronous, active-high reset.
REQ-007 req_i  in  4  per-channel packet-pending flag from the RX channel FIFOs.
REQ-008 sp_i  in  4  per-channel short-packet flag, valid while req_i is set.
REQ-009 wc_i  in  64  per-channel 16-bit word count; channel n uses bits [16n+15:16n].
REQ-010 hs_ready_i  in  1  TX link reports HS mode active.
REQ-011 grant_o  out  4  one-hot grant; all zero when no channel is granted.
REQ-012 ch_o  out  2  index of the granted channel.
REQ-013 rd_en_o  out  1  read strobe to the granted channel FIFO; one beat per cycle.
REQ-014 eop_o  out  1  single-cycle pulse coincident with the last rd_en_o of a packet.
REQ-015 hs_req_o  out  1  request to the TX link to enter or hold HS mode.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 err_o  out  1  single-cycle pulse on HS timeout.

Function
REQ-018 The state machine shall have the states IDLE, HS_REQ, XFER, TRAIL and GAP.
REQ-019 IDLE, when any req_i bit is set: grant the first requesting channel searching round-robin from ptr, register its sp/wc, and go to HS_REQ.
REQ-020 ptr shall advance to (granted index + 1) mod 4 only when XFER completes.
REQ-021 HS_REQ: hs_req_o=1 and timer counts; when hs_ready_i=1, go to XFER the next cycle.
REQ-022 HS_REQ timeout: when the timer reaches HS_TIMEOUT, pulse err_o, clear grant_o and hs_req_o, leave ptr unchanged, and go to IDLE.
REQ-023 Packet bytes: 4 for a short packet; wc+6 for a long packet.
REQ-024 Beats = ceil(bytes/BPB), computed in 17 bits; wc=0xFFFF gives 65541 bytes with no overflow.
REQ-025 XFER: rd_en_o=1 on every cycle, regardless of hs_ready_i.
REQ-026 XFER: eop_o=1 on the final beat, then go to TRAIL.
REQ-027 XFER beat count: exactly Beats rd_en_o cycles.
REQ-028 XFER and TRAIL: grant_o and ch_o stay stable; changes on req_i, sp_i and wc_i are ignored.
REQ-029 TRAIL: hs_req_o=0 and grant_o=0; wait for hs_ready_i=0, then go to GAP.
REQ-030 GAP: count PKT_GAP cycles, then go to IDLE.
REQ-031 A request that arrives during GAP is granted on its first IDLE cycle.
REQ-032 rd_en_o, eop_o and err_o shall be registered outputs.
REQ-033 grant_o is zero outside the HS_REQ and XFER states.
REQ-034 ch_o holds its last value when no channel is granted.

Reset
REQ-035 When reset_byte_i=1 at a clock edge, state goes to IDLE and ptr goes to 0, taking effect at that edge.
REQ-036 Outputs after that edge: grant_o=0, ch_o=0, rd_en_o=0, eop_o=0, hs_req_o=0, busy_o=0, err_o=0.
REQ-037 Counters and registered sp/wc shall be cleared at that edge.
REQ-038 Reset during XFER shall abort the packet without producing eop_o.
REQ-039 After reset is released, the first possible grant occurs one cycle later.

Verification
REQ-040 RX_GEAR=8, only ch2 requests, long packet, wc=10, hs_ready_i rises 3 cycles after hs_req_o -> grant_o=0100, 16 rd_en_o cycles, eop_o on the 16th, then hs_req_o=0.
REQ-041 RX_GEAR=16, short packet on ch0 -> 2 rd_en_o cycles with eop_o on the 2nd; long packet wc=1 -> ceil(7/2)=4 beats.
REQ-042 All four channels request continuously, ptr=0 -> grant order 0,1,2,3,0, with at least PKT_GAP idle cycles between consecutive grants.
REQ-043 hs_ready_i held at 0 with HS_TIMEOUT=8 -> err_o pulses once after 8 cycles in HS_REQ, grant_o clears, and the same channel is granted again next.
REQ-044 reset_byte_i asserted mid-XFER for 1 cycle -> all outputs 0 at that edge, no eop_o, and ptr=0 afterwards.
REQ-045 wc=0xFFFF at RX_GEAR=8 -> exactly 65541 rd_en_o cycles with no counter wrap.
